// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU result transmitter.
// The optional parity feature is selected by the ALU_TX_PARITY_EN macro.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [4:0] ALU_TX_HDR_TAG   = 5'b10100;
    localparam int         ALU_TX_DATA_BITS = 8;
    localparam int         ALU_SEL_W        = 3;

    // Header byte: fixed tag in the upper bits, ALU select in the lower bits.
    function automatic logic [7:0] hdr_byte(input logic [ALU_SEL_W-1:0] sel);
        return {ALU_TX_HDR_TAG, sel};
    endfunction

endpackage

// File: rtl/alu_baud_tick.sv
// alu_baud_tick: bit-time counter. Counts 0..CLKS_PER_BIT-1 and emits a
// one-cycle tick on the last count. restart holds the count at zero so a
// new bit always starts with a full bit time.
module alu_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign tick = !restart && (cnt == CW'(CLKS_PER_BIT - 1));

    // Bit-time counter: wraps on tick, cleared while restarting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_result_tx.sv
// alu_result_tx: sends an ALU select/result pair as a two-byte serial frame
// (header {tag, sel} then result), each byte start/8 data LSB-first/stop.
// Define ALU_TX_PARITY_EN to insert an even-parity bit before each stop bit.
//
// state  | meaning
// IDLE   | line high, ready for a new request
// START  | start bit (0)
// DATA   | data bits, LSB first from the shift register
// PARITY | even parity of the current byte (parity build only)
// STOP   | stop bit (1); then next byte or back to IDLE
import alu_pkg::*;

module alu_result_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           y_in,
    input  logic [ALU_SEL_W-1:0] sel_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    tx_state_t  state;
    logic [7:0] shift;
    logic [7:0] result_q;
    logic [2:0] bit_idx;
    logic       byte_idx;
    logic       tick;
`ifdef ALU_TX_PARITY_EN
    logic       par;
`endif

    assign ready = (state == IDLE);
    assign busy  = !ready;

    alu_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state == IDLE),
        .tick    (tick)
    );

    // Frame sequencer; tx is loaded with the value of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            result_q <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
            tx       <= 1'b1;
            done     <= 1'b0;
`ifdef ALU_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (valid) begin
                        shift    <= hdr_byte(sel_in);
                        result_q <= y_in;
                        byte_idx <= 1'b0;
                        tx       <= 1'b0;
                        state    <= START;
`ifdef ALU_TX_PARITY_EN
                        par      <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
`ifdef ALU_TX_PARITY_EN
                        par <= par ^ shift[0];
`endif
                        if (bit_idx == 3'(ALU_TX_DATA_BITS - 1)) begin
`ifdef ALU_TX_PARITY_EN
                            tx    <= par ^ shift[0];
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end
                end
`ifdef ALU_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (!byte_idx) begin
                            shift    <= result_q;
                            byte_idx <= 1'b1;
                            tx       <= 1'b0;
                            state    <= START;
`ifdef ALU_TX_PARITY_EN
                            par      <= 1'b0;
`endif
                        end else begin
                            tx    <= 1'b1;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_tx.sv
// tb_alu_result_tx: directed bench for alu_result_tx. Instance a uses
// CLKS_PER_BIT=4, instance b uses CLKS_PER_BIT=2. Honours ALU_TX_PARITY_EN.
module tb_alu_result_tx;

`ifdef ALU_TX_PARITY_EN
    localparam int BC = 11;
`else
    localparam int BC = 10;
`endif
    localparam int FC = 2 * BC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic [7:0] y_a = 8'h00, y_b = 8'h00;
    logic [2:0] sel_a = 3'd0, sel_b = 3'd0;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_tx #(.CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .y_in(y_a), .sel_in(sel_a), .valid(valid_a),
        .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    alu_result_tx #(.CLKS_PER_BIT(2)) dut_b (
        .clk(clk), .rst(rst), .y_in(y_b), .sel_in(sel_b), .valid(valid_b),
        .ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] byte_cells(input logic [7:0] b);
        logic [21:0] s;
        s = '0;
        s = {s[20:0], 1'b0};
        for (int i = 0; i < 8; i++) s = {s[20:0], b[i]};
`ifdef ALU_TX_PARITY_EN
        s = {s[20:0], ^b};
`endif
        s = {s[20:0], 1'b1};
        return s;
    endfunction

    function automatic logic [21:0] frame_seq(input logic [7:0] y, input logic [2:0] sel);
        return (byte_cells({5'b10100, sel}) << BC) | byte_cells(y);
    endfunction

    // Samples one frame on falling edges. Sample 0 is the cycle after the
    // accept edge; sample FC*c must show the done pulse.
    // mode 0: drop valid after accept; 1: keep valid with y=FF until the
    // final bit cycle; 2: keep valid asserted throughout.
    task automatic capture(input int inst, input int c, input int mode,
                           output logic [21:0] seq, output int glitch,
                           output int bad, output int early,
                           output logic end_tx, output logic end_done,
                           output logic end_ready);
        int   fl;
        logic t, d, r, b;
        fl = FC * c;
        seq = '0; glitch = 0; bad = 0; early = 0;
        end_tx = 1'b0; end_done = 1'b0; end_ready = 1'b0;
        for (int n = 0; n <= fl; n++) begin
            @(negedge clk);
            t = (inst == 0) ? tx_a    : tx_b;
            d = (inst == 0) ? done_a  : done_b;
            r = (inst == 0) ? ready_a : ready_b;
            b = (inst == 0) ? busy_a  : busy_b;
            if (n < fl) begin
                if (n % c == 0) seq = {seq[20:0], t};
                else if (t !== seq[0]) glitch++;
                if (b !== 1'b1 || r !== 1'b0) bad++;
                if (d !== 1'b0) early++;
            end else begin
                end_tx = t; end_done = d; end_ready = r;
            end
            if (mode == 0 && n == 0) begin
                if (inst == 0) valid_a = 1'b0; else valid_b = 1'b0;
            end
            if (mode == 1 && n == 0) begin
                y_a = 8'hFF; sel_a = 3'd0;
            end
            if (mode == 1 && n == fl - 1) valid_a = 1'b0;
        end
    endtask

    task automatic frame_checks(input string tag, input logic [21:0] seq,
                                input logic [21:0] exp, input int glitch,
                                input int bad, input int early, input logic end_tx,
                                input logic end_done, input logic end_ready);
        chk({tag, "_bits"}, 32'(seq), 32'(exp));
        chk({tag, "_bit_width"}, glitch, 0);
        chk({tag, "_busy_ready"}, bad, 0);
        chk({tag, "_early_done"}, early, 0);
        chk({tag, "_end_tx"}, 32'(end_tx), 1);
        chk({tag, "_done"}, 32'(end_done), 1);
        chk({tag, "_end_ready"}, 32'(end_ready), 1);
    endtask

    logic [21:0] seq, lit;
    int          glitch, bad, early, dones, rst_n;
    logic        etx, edn, erd;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_a", 32'(tx_a), 1);
        chk("rst_ready_a", 32'(ready_a), 1);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_tx_b", 32'(tx_b), 1);
        chk("rst_ready_b", 32'(ready_b), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready_a", 32'(ready_a), 1);

        // Nominal frame 0x5A / sel 3 with valid+0xFF driven while busy
`ifdef ALU_TX_PARITY_EN
        lit = 22'b01100010101_00101101001;
`else
        lit = 22'(20'b0110001011_0010110101);
`endif
        valid_a = 1'b1; y_a = 8'h5A; sel_a = 3'd3;
        capture(0, 4, 1, seq, glitch, bad, early, etx, edn, erd);
        frame_checks("nominal", seq, lit, glitch, bad, early, etx, edn, erd);
        @(negedge clk);
        chk("nominal_done_once", 32'(done_a), 0);
        chk("nominal_no_reaccept", 32'(busy_a), 0);

        // Parity vector 0x07 / sel 0
`ifdef ALU_TX_PARITY_EN
        lit = 22'b00000010101_01110000011;
`else
        lit = 22'(20'b0000001011_0111000001);
`endif
        valid_a = 1'b1; y_a = 8'h07; sel_a = 3'd0;
        capture(0, 4, 0, seq, glitch, bad, early, etx, edn, erd);
        frame_checks("par07", seq, lit, glitch, bad, early, etx, edn, erd);
        @(negedge clk);

        // Back-to-back frames with valid held high
        valid_a = 1'b1; y_a = 8'hC3; sel_a = 3'd5;
        capture(0, 4, 2, seq, glitch, bad, early, etx, edn, erd);
        frame_checks("b2b_first", seq, frame_seq(8'hC3, 3'd5), glitch, bad, early, etx, edn, erd);
        dones = early + int'(edn);
        y_a = 8'h3C; sel_a = 3'd2;
        capture(0, 4, 0, seq, glitch, bad, early, etx, edn, erd);
        frame_checks("b2b_second", seq, frame_seq(8'h3C, 3'd2), glitch, bad, early, etx, edn, erd);
        dones = dones + early + int'(edn);
        @(negedge clk);
        dones = dones + int'(done_a);
        chk("b2b_done_pulses", dones, 2);

        // Reset during result data bit 3
        valid_a = 1'b1; y_a = 8'h00; sel_a = 3'd1;
        rst_n = (BC + 4) * 4 + 1;
        dones = 0;
        for (int n = 0; n <= rst_n; n++) begin
            @(negedge clk);
            if (n == 0) valid_a = 1'b0;
            dones = dones + int'(done_a);
        end
        chk("midrst_pre_tx", 32'(tx_a), 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx_a), 1);
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_ready", 32'(ready_a), 1);
        repeat (3) begin
            @(negedge clk);
            dones = dones + int'(done_a);
        end
        rst = 1'b0;
        valid_a = 1'b1; y_a = 8'h01; sel_a = 3'd6;
        capture(0, 4, 0, seq, glitch, bad, early, etx, edn, erd);
        chk("midrst_no_done", dones, 0);
        frame_checks("after_rst", seq, frame_seq(8'h01, 3'd6), glitch, bad, early, etx, edn, erd);
        @(negedge clk);

        // Divider corner: CLKS_PER_BIT=2, 0x00 / sel 7
`ifdef ALU_TX_PARITY_EN
        lit = 22'b01110010111_00000000001;
`else
        lit = 22'(20'b0111001011_0000000001);
`endif
        valid_b = 1'b1; y_b = 8'h00; sel_b = 3'd7;
        capture(1, 2, 0, seq, glitch, bad, early, etx, edn, erd);
        frame_checks("div2", seq, lit, glitch, bad, early, etx, edn, erd);
        @(negedge clk);
        chk("div2_done_once", 32'(done_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_tx.md
# alu_result_tx

Serial result transmitter for the 4-bit-operand ALU. It accepts one ALU result plus its 3-bit operation select through a valid/ready handshake. It then sends both out on a single line as a two-byte UART-style frame: a header byte carrying the select, followed by the result byte. It sits downstream of the ALU in the tile, so an off-chip reader can collect results over one pin instead of the 8-bit parallel output bus.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..1023.

Ports:
- clk  input  1  single design clock; all state is on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- y_in  input  8  ALU result to transmit.
- sel_in  input  3  ALU select that produced y_in.
- valid  input  1  request to send y_in/sel_in.
- ready  output  1  block is idle and will accept on this cycle.
- tx  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when the frame completes.

## Operation
- Handshake: a transfer is accepted on a rising edge where valid=1 and ready=1.
  - y_in and sel_in are captured into internal registers at that edge.
  - Inputs are don't-care at all other times.
  - valid while busy is ignored; nothing is queued.
- Header byte = {5'b10100, sel}. Sent first, followed by the result byte.
- Per-byte format:
  - start bit (0);
  - 8 data bits, LSB first;
  - [parity bit, only when enabled];
  - stop bit (1).
- State machine:
  - IDLE: tx=1, ready=1. On accept, go to START with byte index 0.
  - START: tx=0. After 1 bit time, go to DATA with bit index 0.
  - DATA: tx=shift[0]. After each bit time, shift right. After bit 7, go to PARITY if enabled, otherwise STOP.
  - PARITY: tx=even parity (XOR) of the current byte. After 1 bit time, go to STOP.
  - STOP: tx=1. After 1 bit time:
    - byte index 0: load the result byte and go to START;
    - byte index 1: go to IDLE and pulse done.
- busy = (state != IDLE). ready = !busy.
- Bit timer: counts 0..CLKS_PER_BIT-1. It reloads on every state or bit change, so no drift accumulates between bytes.
- Reset values: tx=1, ready=1, busy=0, done=0, state=IDLE, all counters 0.

## Timing
- Accept at edge k:
  - tx falls after edge k (registered output).
  - busy=1 and ready=0 from edge k.
- Each bit holds for exactly CLKS_PER_BIT cycles.
- There is no idle gap between header stop bit and result start bit.
- Frame length: 20*CLKS_PER_BIT cycles, or 22*CLKS_PER_BIT with parity.
- At the last stop-bit cycle boundary, in a single edge:
  - state returns to IDLE;
  - done=1 for exactly one cycle;
  - ready=1.
- valid held high continuously: the next accept happens on the cycle ready is seen high. Back-to-back frames are therefore separated by exactly 1 idle cycle with tx=1.
- rst asserted mid-frame: tx=1 immediately (asynchronous), state=IDLE, captured data discarded. No done pulse is issued.
- rst released: the block is ready on the first clock edge.

## Configuration
- ALU_TX_PARITY_EN defined:
  - each byte carries an even-parity bit between data bit 7 and the stop bit;
  - a byte is 11 bits.
- ALU_TX_PARITY_EN undefined:
  - the PARITY state and parity logic are absent;
  - a byte is 10 bits.

## Structure
- Package alu_pkg holds:
  - tx state enum (IDLE, START, DATA, PARITY, STOP);
  - ALU_TX_HDR_TAG = 5'b10100;
  - ALU_TX_DATA_BITS = 8;
  - ALU_SEL_W = 3.
- Sub-module alu_baud_tick: bit-time counter with a restart input and a one-cycle tick output, parameterised by CLKS_PER_BIT.
- The FSM, shift register and byte index live in the top module.

## Test plan
- Nominal frame, CLKS_PER_BIT=4, no parity. Accept y_in=0x5A, sel_in=3'd3.
  - Header 0xA3: tx = 0,1,1,0,0,0,1,0,1,1.
  - Result 0x5A: tx = 0,0,1,0,1,1,0,1,0,1.
  - Each bit lasts 4 cycles; done pulses at cycle 80 after accept.
- Parity build (ALU_TX_PARITY_EN), y_in=0x07, sel_in=3'd0.
  - Header 0xA0 has parity bit 0; result 0x07 has parity bit 1.
  - Frame is 88 cycles at CLKS_PER_BIT=4.
- Busy rejection: during the frame, drive valid=1 with y_in=0xFF.
  - The transmitted result stays 0x5A and ready stays 0 until done.
- Back-to-back: hold valid=1 across two frames.
  - Exactly one tx=1 idle cycle between the second stop bit and the next start bit.
  - Exactly two done pulses.
- Reset mid-frame: assert rst during result bit 3.
  - tx=1 in the same cycle; no done pulse.
  - After release, a new accept of y_in=0x01 transmits correctly.
- Divider corner: CLKS_PER_BIT=2, y_in=0x00, sel_in=3'd7.
  - Header 0xA7 is sent, followed by all-zero data bits, with each bit lasting 2 cycles.
